instr_seq: RTL and testbench
============================

Name: instr_seq

Overview:
Parametrised successor to the fixed instruction ROM: a writable program store plus a program counter for one TIS node.
- Each cycle it presents the current instruction word.
- It resolves sequencing (wrap at program length) and all branch classes (JMP/JEZ/JNZ/JGZ/JLZ/JRO) from the fed-back branch op, ACC and jump offset.
- It supports stall, in-field reprogramming and an optional preloaded image.
- Sits between the node's decoder/ALU and its port logic.

Parameters:
INSTR_W, 21, instruction word width
DATA_W, 11, signed ACC / jump offset width
DEPTH, 16, program lines (max program length)
ADDR_W, $clog2(DEPTH), PC / address width (derived)
INIT_FILE, "", $readmemb image loaded at elaboration; empty = no preload
INIT_LEN, 0, program length valid after reset (0..DEPTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-low
op  in  4  branch class of the currently presented instruction (tis_isa_pkg encoding)
acc  in  DATA_W  signed accumulator
jmp_off  in  DATA_W  signed: absolute label for JMP/Jcc, relative offset for JRO
stall  in  1  hold PC and instruction (blocked port I/O)
prog_we  in  1  program write strobe
prog_addr  in  ADDR_W  write address
prog_data  in  INSTR_W  write data
prog_commit  in  1  latch prog_len and restart at line 0
prog_len  in  ADDR_W+1  program length sampled on commit
out  out  INSTR_W  current instruction word
pc  out  ADDR_W  address of out
valid  out  1  out/pc hold a live instruction

Behaviour:
- Reset (reset==0 at a rising edge):
  - pc=0, out=0, valid=0, len=INIT_LEN.
  - Next state is PRIME if INIT_LEN>0, else EMPTY.
  - Memory contents are preserved.
- States: EMPTY, LOAD, PRIME, RUN.
  - EMPTY: valid=0, out=0; waits for prog_we/prog_commit.
  - LOAD: entered on any prog_we in any state; valid=0, pc=0.
  - PRIME: one cycle; out<=mem[0], pc<=0, valid<=1 -> RUN.
  - RUN: advances per the rules below.
- Writes: prog_we writes mem[prog_addr]<=prog_data in every state. prog_addr>=DEPTH is ignored.
- Commit:
  - Accepted in any state: len<=min(prog_len,DEPTH).
  - len==0 -> EMPTY; otherwise -> PRIME.
  - prog_we and prog_commit together: the write is performed and commit takes effect. PRIME's read on the following cycle sees the write.
  - Commit has priority over the prog_we->LOAD transition.
- RUN with stall=1: pc, out and valid unchanged.
- RUN with stall=0: pc<=nxt, out<=mem[nxt] on the same edge (0-cycle skew between pc and out).
- nxt computation:
  - SEQ: pc+1, wraps to 0 when pc+1==len.
  - JMP: clamp(jmp_off, 0, len-1).
  - JEZ/JNZ/JGZ/JLZ: condition acc==0 / !=0 / >0 / <0 (signed). Taken -> clamp(jmp_off,0,len-1); not taken -> SEQ.
  - JRO: clamp(pc+jmp_off, 0, len-1). Evaluate in DATA_W+2 signed bits so there is no overflow. jmp_off=0 repeats the same line.
  - Op codes 7..15: treated as SEQ.
- len==1: SEQ stays at 0.
- acc=-1024 (most negative): JLZ taken, JGZ not taken.

Decomposition:
- tis_isa_pkg (shared):
  - Branch op localparams: BR_SEQ=0, BR_JMP=1, BR_JEZ=2, BR_JNZ=3, BR_JGZ=4, BR_JLZ=5, BR_JRO=6.
  - INSTR_W and DATA_W defaults.
  - State encoding.
- Sub-module instr_seq_next_pc: purely combinational (op, acc, jmp_off, pc, len) -> nxt, including clamp and wrap.
- instr_seq holds the memory, the FSM and the registers.

Test Plan:
1. Load/prime/wrap: INIT_LEN=0, reset low 2 cycles; write 1,2,3 to addr 0..2 and commit len=3; op=SEQ, stall=0.
   -> The edge after commit is PRIME; next edge gives out=1, pc=0, valid=1.
   -> out then runs 2,3,1,2 (wrap).
2. Conditional: len=8, pc=2, op=JEZ, jmp_off=5.
   -> acc=0 gives pc=5, out=mem[5]; acc=3 gives pc=3.
   -> op=JNZ, acc=3 gives pc=5.
3. JRO clamp: len=8, pc=2.
   -> jmp_off=-4 gives pc=0; jmp_off=20 gives pc=7; jmp_off=0 holds pc=2 every cycle.
4. Sign edge: acc=-1024.
   -> JLZ with jmp_off=4 gives pc=4; JGZ is not taken (pc+1).
   -> JMP with jmp_off=12, len=8 gives pc=7; op=9 behaves as SEQ.
5. Stall/reprogram: stall high 3 cycles in RUN -> pc/out constant.
   -> prog_we during RUN -> next edge valid=0, LOAD.
   -> commit len=0 -> EMPTY with out=0, valid=0.
6. Reset mid-run (INIT_LEN=4, preloaded): reset=0 at pc=3.
   -> Next edge gives pc=0, out=0, valid=0.
   -> After release, PRIME then out=mem[0], valid=1; memory unchanged.

Source files
------------

// File: rtl/tis_isa_pkg.sv
// Shared TIS node definitions: branch classes fed back from the decoder,
// default datapath widths and the instruction sequencer state encoding.
package tis_isa_pkg;

  localparam int TIS_INSTR_W = 21;
  localparam int TIS_DATA_W  = 11;

  localparam logic [3:0] BR_SEQ = 4'd0;
  localparam logic [3:0] BR_JMP = 4'd1;
  localparam logic [3:0] BR_JEZ = 4'd2;
  localparam logic [3:0] BR_JNZ = 4'd3;
  localparam logic [3:0] BR_JGZ = 4'd4;
  localparam logic [3:0] BR_JLZ = 4'd5;
  localparam logic [3:0] BR_JRO = 4'd6;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PRIME = 2'd2,
    ST_RUN   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/instr_seq_next_pc.sv
// Next program line from branch class, ACC, jump offset, current pc and length.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to take nxt (stall).
module instr_seq_next_pc
  import tis_isa_pkg::*;
#(
  parameter int DATA_W = TIS_DATA_W,
  parameter int ADDR_W = 4
) (
  input  logic [3:0]               op,
  input  logic signed [DATA_W-1:0] acc,
  input  logic signed [DATA_W-1:0] jmp_off,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [ADDR_W:0]          len,
  output logic [ADDR_W-1:0]        nxt
);

  // Wide enough that pc + jmp_off can never overflow before clamping.
  localparam int CW = ((DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1) + 2;

  logic [ADDR_W:0]      pc_inc;
  logic [ADDR_W-1:0]    seq_pc;
  logic [ADDR_W-1:0]    tgt_pc;
  logic signed [CW-1:0] off_x;
  logic signed [CW-1:0] pc_x;
  logic signed [CW-1:0] hi_x;
  logic signed [CW-1:0] tgt_x;
  logic                 acc_zero;
  logic                 acc_neg;
  logic                 taken;

  assign pc_inc   = {1'b0, pc} + (ADDR_W + 1)'(1);
  assign seq_pc   = (pc_inc >= len) ? '0 : pc_inc[ADDR_W-1:0];
  assign off_x    = {{(CW - DATA_W){jmp_off[DATA_W-1]}}, jmp_off};
  assign pc_x     = {{(CW - ADDR_W){1'b0}}, pc};
  assign hi_x     = {{(CW - ADDR_W - 1){1'b0}}, len} - CW'(1);
  assign acc_zero = (acc == '0);
  assign acc_neg  = acc[DATA_W-1];

  always_comb begin
    taken = 1'b0;
    tgt_x = off_x;
    case (op)
      BR_JMP: taken = 1'b1;
      BR_JEZ: taken = acc_zero;
      BR_JNZ: taken = !acc_zero;
      BR_JGZ: taken = !acc_zero && !acc_neg;
      BR_JLZ: taken = acc_neg;
      BR_JRO: begin
        taken = 1'b1;
        tgt_x = pc_x + off_x;
      end
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    if (tgt_x[CW-1]) begin
      tgt_pc = '0;
    end else if (tgt_x > hi_x) begin
      tgt_pc = hi_x[ADDR_W-1:0];
    end else begin
      tgt_pc = tgt_x[ADDR_W-1:0];
    end
  end

  // An empty program has no legal line; park at 0.
  assign nxt = (len == '0) ? '0 : (taken ? tgt_pc : seq_pc);

endmodule

// File: rtl/instr_seq.sv
// Writable program store and program counter for one TIS node.
// Latency: pc and out update together on the edge; first line appears one cycle after commit.
// Backpressure: stall holds pc/out/valid; any program write drops valid until the next commit.
module instr_seq
  import tis_isa_pkg::*;
#(
  parameter int    INSTR_W   = TIS_INSTR_W,
  parameter int    DATA_W    = TIS_DATA_W,
  parameter int    DEPTH     = 16,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter string INIT_FILE = "",
  parameter int    INIT_LEN  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                op,
  input  logic signed [DATA_W-1:0]  acc,
  input  logic signed [DATA_W-1:0]  jmp_off,
  input  logic                      stall,
  input  logic                      prog_we,
  input  logic [ADDR_W-1:0]         prog_addr,
  input  logic [INSTR_W-1:0]        prog_data,
  input  logic                      prog_commit,
  input  logic [ADDR_W:0]           prog_len,
  output logic [INSTR_W-1:0]        out,
  output logic [ADDR_W-1:0]         pc,
  output logic                      valid
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] INIT_L  = (ADDR_W + 1)'(INIT_LEN);

  logic [INSTR_W-1:0] mem [DEPTH];
  seq_state_t         state;
  logic [ADDR_W:0]    len;
  logic [ADDR_W:0]    commit_len;
  logic [ADDR_W-1:0]  nxt;
  logic               addr_ok;

  assign addr_ok    = ({1'b0, prog_addr} < DEPTH_L);
  assign commit_len = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

  // The store is deliberately outside reset so a node reset keeps its program.
  always_ff @(posedge clk) begin
    if (prog_we && addr_ok) begin
      mem[prog_addr] <= prog_data;
    end
  end

  instr_seq_next_pc #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .op      (op),
    .acc     (acc),
    .jmp_off (jmp_off),
    .pc      (pc),
    .len     (len),
    .nxt     (nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= (INIT_LEN > 0) ? ST_PRIME : ST_EMPTY;
      len   <= INIT_L;
      pc    <= '0;
      out   <= '0;
      valid <= 1'b0;
    end else if (prog_commit) begin
      // Commit wins over a simultaneous write; the write still lands before PRIME reads.
      len   <= commit_len;
      state <= (commit_len == '0) ? ST_EMPTY : ST_PRIME;
      pc    <= '0;
      out   <= '0;
      valid <= 1'b0;
    end else if (prog_we) begin
      state <= ST_LOAD;
      pc    <= '0;
      out   <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        ST_PRIME: begin
          out   <= mem[0];
          pc    <= '0;
          valid <= 1'b1;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (!stall) begin
            pc  <= nxt;
            out <= mem[nxt];
          end
        end
        default: begin
          out   <= '0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_seq.sv
// Self-checking bench for instr_seq: directed vectors, corner sequences and
// randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_instr_seq;
  import tis_isa_pkg::*;

  localparam int INSTR_W = 21;
  localparam int DATA_W  = 11;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset_a, reset_b;
  logic [3:0]               op;
  logic signed [DATA_W-1:0] acc, jmp_off;
  logic                     stall, prog_we, prog_commit;
  logic [ADDR_W-1:0]        prog_addr;
  logic [INSTR_W-1:0]       prog_data;
  logic [ADDR_W:0]          prog_len;
  logic [INSTR_W-1:0]       out_a, out_b;
  logic [ADDR_W-1:0]        pc_a, pc_b;
  logic                     valid_a, valid_b;

  instr_seq #(.INIT_LEN(0)) dut_a (
    .clk(clk), .reset(reset_a), .op(op), .acc(acc), .jmp_off(jmp_off), .stall(stall),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_commit(prog_commit), .prog_len(prog_len),
    .out(out_a), .pc(pc_a), .valid(valid_a)
  );

  instr_seq #(.INIT_LEN(4)) dut_b (
    .clk(clk), .reset(reset_b), .op(op), .acc(acc), .jmp_off(jmp_off), .stall(stall),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_commit(prog_commit), .prog_len(prog_len),
    .out(out_b), .pc(pc_b), .valid(valid_b)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] op;
    int         acc;
    int         off;
    int         exp_pc;
  } vec_t;
  vec_t vecs[16];

  // Reference model state (dut_a)
  int m_mem[DEPTH];
  int m_len, m_pc, m_out, m_valid, m_phase; // phase: 0 idle, 1 priming, 2 running

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    prog_we   = 1'b1;
    prog_addr = 4'(a);
    prog_data = 21'(d);
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic commit(input int l);
    prog_commit = 1'b1;
    prog_len    = 5'(l);
    tick();
    prog_commit = 1'b0;
  endtask

  task automatic br(input logic [3:0] o, input int a, input int f);
    op      = o;
    acc     = 11'(a);
    jmp_off = 11'(f);
  endtask

  task automatic chk_a(input string name, input int e_pc, input int e_out, input int e_valid);
    chk({name, ".pc"},    int'(pc_a),    e_pc);
    chk({name, ".out"},   int'(out_a),   e_out);
    chk({name, ".valid"}, int'(valid_a), e_valid);
  endtask

  function automatic int clampi(input int v, input int len);
    if (v < 0) return 0;
    if (v > len - 1) return len - 1;
    return v;
  endfunction

  function automatic int ref_next(input int opc, input int a, input int o, input int p, input int len);
    int seq;
    seq = (p + 1 == len) ? 0 : p + 1;
    case (opc)
      1: return clampi(o, len);
      2: return (a == 0) ? clampi(o, len) : seq;
      3: return (a != 0) ? clampi(o, len) : seq;
      4: return (a > 0)  ? clampi(o, len) : seq;
      5: return (a < 0)  ? clampi(o, len) : seq;
      6: return clampi(p + o, len);
      default: return seq;
    endcase
  endfunction

  task automatic model_step();
    int l;
    if (!reset_a) begin
      m_pc = 0; m_out = 0; m_valid = 0; m_len = 0; m_phase = 0;
    end else begin
      if (prog_we) m_mem[int'(prog_addr)] = int'(prog_data);
      if (prog_commit) begin
        l = int'(prog_len);
        m_len = (l > DEPTH) ? DEPTH : l;
        m_pc = 0; m_out = 0; m_valid = 0;
        m_phase = (m_len > 0) ? 1 : 0;
      end else if (prog_we) begin
        m_pc = 0; m_out = 0; m_valid = 0; m_phase = 0;
      end else if (m_phase == 1) begin
        m_pc = 0; m_out = m_mem[0]; m_valid = 1; m_phase = 2;
      end else if (m_phase == 2 && !stall) begin
        m_pc  = ref_next(int'(op), int'(acc), int'(jmp_off), m_pc, m_len);
        m_out = m_mem[m_pc];
      end
    end
  endtask

  initial begin
    vecs[0]  = '{BR_JEZ, 0,     5,  5};
    vecs[1]  = '{BR_JEZ, 3,     5,  3};
    vecs[2]  = '{BR_JNZ, 3,     5,  5};
    vecs[3]  = '{BR_JNZ, 0,     5,  3};
    vecs[4]  = '{BR_JRO, 0,    -4,  0};
    vecs[5]  = '{BR_JRO, 0,    20,  7};
    vecs[6]  = '{BR_JRO, 0,     0,  2};
    vecs[7]  = '{BR_JRO, 7,     3,  5};
    vecs[8]  = '{BR_JLZ, -1024, 4,  4};
    vecs[9]  = '{BR_JGZ, -1024, 4,  3};
    vecs[10] = '{BR_JGZ, 1023,  4,  4};
    vecs[11] = '{BR_JMP, 0,    12,  7};
    vecs[12] = '{BR_JMP, 0,    -5,  0};
    vecs[13] = '{4'd9,   0,     5,  3};
    vecs[14] = '{BR_SEQ, 0,     6,  3};
    vecs[15] = '{BR_JLZ, 5,     6,  3};

    reset_a = 1'b0; reset_b = 1'b0;
    br(BR_SEQ, 0, 0);
    stall = 1'b0; prog_we = 1'b0; prog_commit = 1'b0;
    prog_addr = '0; prog_data = '0; prog_len = '0;
    tick(); tick();
    chk_a("reset_a", 0, 0, 0);
    chk("reset_b.pc", int'(pc_b), 0);
    chk("reset_b.valid", int'(valid_b), 0);
    reset_a = 1'b1; reset_b = 1'b1;
    tick();
    chk("empty_a.valid", int'(valid_a), 0);
    chk("preload_b.valid", int'(valid_b), 1);
    chk("preload_b.pc", int'(pc_b), 0);

    // Load, prime and wrap
    wr(0, 1); wr(1, 2); wr(2, 3);
    commit(3);
    chk_a("after_commit", 0, 0, 0);
    tick();
    chk_a("prime", 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a("wrap", (i + 1) % 3, ((i + 1) % 3) + 1, 1);
    end

    // Branch vectors from pc=2 with len=8
    for (int i = 0; i < 8; i++) wr(i, 100 + i);
    commit(8);
    tick();
    chk_a("prime8", 0, 100, 1);
    for (int i = 0; i < 16; i++) begin
      br(BR_JMP, 0, 2);
      tick();
      chk("vec_setup.pc", int'(pc_a), 2);
      br(vecs[i].op, vecs[i].acc, vecs[i].off);
      tick();
      chk($sformatf("vec%0d.pc", i), int'(pc_a), vecs[i].exp_pc);
      chk($sformatf("vec%0d.out", i), int'(out_a), 100 + vecs[i].exp_pc);
    end

    // JRO 0 repeats the same line
    br(BR_JMP, 0, 2); tick();
    br(BR_JRO, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("jro_hold", 2, 102, 1);
    end

    // Stall holds everything
    br(BR_JMP, 0, 4); tick();
    chk_a("stall_setup", 4, 104, 1);
    br(BR_JMP, 0, 6); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("stall", 4, 104, 1);
    end
    stall = 1'b0; br(BR_SEQ, 0, 0);
    tick();
    chk_a("unstall", 5, 105, 1);

    // Reprogram during RUN, then empty commit
    wr(9, 7);
    chk_a("load", 0, 0, 0);
    commit(0);
    chk_a("commit0", 0, 0, 0);
    tick();
    chk_a("empty", 0, 0, 0);

    // Write and commit on the same edge; PRIME sees the new word
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 21'd55;
    prog_commit = 1'b1; prog_len = 5'd2;
    tick();
    prog_we = 1'b0; prog_commit = 1'b0;
    chk_a("we_commit", 0, 0, 0);
    tick();
    chk_a("we_commit_prime", 0, 55, 1);
    tick();
    chk_a("len2_seq", 1, 101, 1);
    tick();
    chk_a("len2_wrap", 0, 55, 1);

    // len==1 stays on line 0
    commit(1);
    tick();
    chk_a("len1_prime", 0, 55, 1);
    tick();
    chk_a("len1_seq", 0, 55, 1);

    // Reset mid-run on the preloaded-length instance
    for (int i = 0; i < 4; i++) wr(i, 200 + i);
    commit(4);
    tick();
    chk("b_prime.out", int'(out_b), 200);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("b_run.pc", int'(pc_b), i);
    end
    reset_b = 1'b0;
    tick();
    chk("b_rst.pc", int'(pc_b), 0);
    chk("b_rst.out", int'(out_b), 0);
    chk("b_rst.valid", int'(valid_b), 0);
    reset_b = 1'b1;
    tick();
    chk("b_reprime.out", int'(out_b), 200);
    chk("b_reprime.valid", int'(valid_b), 1);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("b_mem.pc", int'(pc_b), i % 4);
      chk("b_mem.out", int'(out_b), 200 + (i % 4));
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < DEPTH; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = 21'($urandom);
      model_step(); tick();
    end
    prog_we = 1'b0;
    prog_commit = 1'b1; prog_len = 5'($urandom_range(1, DEPTH));
    model_step(); tick();
    prog_commit = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int r, av;
      r = int'($urandom_range(0, 99));
      reset_a = (r == 99) ? 1'b0 : 1'b1;
      prog_we = (r < 4) ? 1'b1 : 1'b0;
      prog_commit = (r >= 2 && r < 7) ? 1'b1 : 1'b0;
      prog_addr = 4'($urandom);
      prog_data = 21'($urandom);
      prog_len = 5'($urandom_range(0, 31));
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: av = 0;
        1: av = -1024;
        2: av = 1023;
        default: av = int'($urandom_range(0, 2047)) - 1024;
      endcase
      acc = 11'(av);
      if ($urandom_range(0, 3) == 0) jmp_off = 11'($urandom);
      else jmp_off = 11'(int'($urandom_range(0, 40)) - 20);
      stall = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
      model_step();
      tick();
      chk("rand.pc", int'(pc_a), m_pc);
      chk("rand.out", int'(out_a), m_out);
      chk("rand.valid", int'(valid_a), m_valid);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
